// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST signature engine: phase FSM encoding,
// default feedback constants and the MISR next-state function.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE, RUN_A, DRAIN_A, CHECK_A, RUN_B, DRAIN_B, CHECK_B, DONE
  } state_e;

  localparam logic [39:0] LFSR_TAPS_DEF = 40'h80_0030_0000;
  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;

  // Evaluated at 64 bits; the caller truncates to its own width w.
  function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                            input logic [63:0] din,
                                            input logic [63:0] poly,
                                            input int unsigned w);
    logic [63:0] nxt;
    nxt = (sig << 1) ^ din;
    if (sig[6'(w - 1)]) nxt = nxt ^ poly;
    return nxt;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting one result word per enabled cycle.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               RES_W = 16,
  parameter logic [RES_W-1:0] POLY  = RES_W'(MISR_POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [RES_W-1:0] din,
  output logic [RES_W-1:0] sig
);

  logic [RES_W-1:0] sig_q, sig_d, nxt;

  always_comb begin
    nxt   = RES_W'(misr_next(64'(sig_q), 64'(din), 64'(POLY), RES_W));
    sig_d = sig_q;
    if (clr)     sig_d = '0;
    else if (en) sig_d = nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_sig_engine.sv
// Two-phase LFSR/MISR self-test of the altitude (A) and battery (B) equations;
// both phases replay the same vector sequence and are checked against goldens.
module bist_sig_engine
  import bist_pkg::*;
#(
  parameter int                  DATA_W    = 8,
  parameter int                  RES_W     = 16,
  parameter int                  NUM_VEC   = 16,
  parameter int                  LATENCY   = 4,
  parameter logic [5*DATA_W-1:0] LFSR_SEED = 40'h00_0000_0ACE,
  parameter logic [5*DATA_W-1:0] LFSR_TAPS = (5*DATA_W)'(LFSR_TAPS_DEF),
  parameter logic [RES_W-1:0]    MISR_POLY = RES_W'(MISR_POLY_DEF),
  parameter logic [RES_W-1:0]    GOLDEN_A  = '0,
  parameter logic [RES_W-1:0]    GOLDEN_B  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_bist,
  input  logic [RES_W-1:0]  result_a,
  input  logic [RES_W-1:0]  result_b,
  output logic [DATA_W-1:0] x1_test,
  output logic [DATA_W-1:0] x2_test,
  output logic [DATA_W-1:0] v_test,
  output logic [DATA_W-1:0] t_test,
  output logic [DATA_W-1:0] c_test,
  output logic              sel_eq_test,
  output logic              bist_active,
  output logic              bist_done,
  output logic              bist_pass,
  output logic              fail_a,
  output logic              fail_b,
  output logic [RES_W-1:0]  sig_a,
  output logic [RES_W-1:0]  sig_b
);

  localparam int LW    = 5 * DATA_W;
  localparam int CNT_W = $clog2(NUM_VEC + 1);
  localparam int DRN_W = $clog2(LATENCY + 1);

  state_e             state_q, state_d;
  logic [LW-1:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic               fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [RES_W-1:0]   sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic               run, phase_b, enter_run, start_ok;
  logic [RES_W-1:0]   misr_sig;

  assign run       = (state_q == RUN_A) || (state_q == RUN_B);
  assign phase_b   = state_q inside {RUN_B, DRAIN_B, CHECK_B};
  assign start_ok  = start_bist && (state_q == IDLE || state_q == DONE);
  assign enter_run = ((state_d == RUN_A) && (state_q != RUN_A)) ||
                     ((state_d == RUN_B) && (state_q != RUN_B));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_bist) state_d = RUN_A;
      RUN_A:   if (vec_cnt_q == CNT_W'(NUM_VEC - 1)) state_d = DRAIN_A;
      DRAIN_A: if (drn_cnt_q == DRN_W'(LATENCY - 1)) state_d = CHECK_A;
      CHECK_A: state_d = RUN_B;
      RUN_B:   if (vec_cnt_q == CNT_W'(NUM_VEC - 1)) state_d = DRAIN_B;
      DRAIN_B: if (drn_cnt_q == DRN_W'(LATENCY - 1)) state_d = CHECK_B;
      CHECK_B: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bist_active = !(state_q == IDLE || state_q == DONE);
    bist_done   = (state_q == DONE);
    bist_pass   = (state_q == DONE) && !(fail_a_q || fail_b_q);
    sel_eq_test = phase_b;
    x1_test     = run ? lfsr_q[1*DATA_W-1:0*DATA_W] : '0;
    x2_test     = run ? lfsr_q[2*DATA_W-1:1*DATA_W] : '0;
    v_test      = run ? lfsr_q[3*DATA_W-1:2*DATA_W] : '0;
    t_test      = run ? lfsr_q[4*DATA_W-1:3*DATA_W] : '0;
    c_test      = run ? lfsr_q[5*DATA_W-1:4*DATA_W] : '0;
  end

  // Entering either RUN state reseeds, so phase B replays phase A's vectors.
  always_comb begin
    lfsr_d     = lfsr_q;
    vec_cnt_d  = vec_cnt_q;
    if (enter_run) begin
      lfsr_d    = LFSR_SEED;
      vec_cnt_d = '0;
    end else if (run) begin
      lfsr_d    = {lfsr_q[LW-2:0], ^(lfsr_q & LFSR_TAPS)};
      vec_cnt_d = vec_cnt_q + 1'b1;
    end
    drn_cnt_d  = (state_q == DRAIN_A || state_q == DRAIN_B) ? drn_cnt_q + 1'b1 : '0;
    vld_pipe_d = LATENCY'({vld_pipe_q, run});
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    sig_a_d    = sig_a_q;
    sig_b_d    = sig_b_q;
    if (start_ok) begin
      fail_a_d = 1'b0;
      fail_b_d = 1'b0;
    end
    if (state_q == CHECK_A) begin
      sig_a_d  = misr_sig;
      fail_a_d = (misr_sig != GOLDEN_A);
    end
    if (state_q == CHECK_B) begin
      sig_b_d  = misr_sig;
      fail_b_d = (misr_sig != GOLDEN_B);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= '0;
      vec_cnt_q  <= '0;
      drn_cnt_q  <= '0;
      vld_pipe_q <= '0;
      fail_a_q   <= 1'b0;
      fail_b_q   <= 1'b0;
      sig_a_q    <= '0;
      sig_b_q    <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      vec_cnt_q  <= vec_cnt_d;
      drn_cnt_q  <= drn_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      sig_a_q    <= sig_a_d;
      sig_b_q    <= sig_b_d;
    end
  end

  bist_misr #(.RES_W(RES_W), .POLY(MISR_POLY)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter_run),
    .en    (vld_pipe_q[LATENCY-1]),
    .din   (phase_b ? result_b : result_a),
    .sig   (misr_sig)
  );

  assign fail_a = fail_a_q;
  assign fail_b = fail_b_q;
  assign sig_a  = sig_a_q;
  assign sig_b  = sig_b_q;

endmodule

// File: tb/tb_bist_sig_engine.sv
// Bench: registered equation datapath model feeding two engine instances
// (defaults, and LATENCY=NUM_VEC=1); expected run results queued at start.
module tb_bist_sig_engine;

  localparam logic [39:0] SEED = 40'h00_0000_0ACE;
  localparam logic [39:0] TAPS = 40'h80_0030_0000;

  // Signature of one phase as the engine should compact it; flt flips bit 0 of that vector.
  function automatic logic [15:0] calc_sig(input bit b, input int nvec, input int flt);
    logic [39:0] l;
    logic [15:0] m, d;
    l = SEED;
    m = '0;
    for (int i = 0; i < nvec; i++) begin
      if (b) d = 16'(int'(l[23:16]) * int'(l[31:24]) + int'(l[39:32]));
      else   d = 16'(3 * int'(l[7:0]) + 5 * int'(l[15:8]));
      if (i == flt) d[0] = ~d[0];
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
      l = {l[38:0], ^(l & TAPS)};
    end
    return m;
  endfunction

  localparam logic [15:0] GA  = calc_sig(1'b0, 16, -1);
  localparam logic [15:0] GB  = calc_sig(1'b1, 16, -1);
  localparam logic [15:0] GA1 = calc_sig(1'b0, 1, -1);
  localparam logic [15:0] GB1 = calc_sig(1'b1, 1, -1);

  typedef struct {
    logic [15:0] sa, sb;
    logic        fa, fb, pass;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0, n_err = 0;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic [7:0]  x1, x2, v, t, c, x1_2, x2_2, v_2, t_2, c_2;
  logic        sel, act, done, pass, fa, fb, sel2, act2, done2, pass2, fa2, fb2;
  logic [15:0] sa, sb, sa2, sb2;
  logic [15:0] pa[4] = '{default: '0};
  logic [15:0] pb[4] = '{default: '0};
  logic [15:0] pa2 = '0, pb2 = '0, ra_now, rb_now;
  logic        sel_d1 = 1'b0;
  bit          fault_en = 1'b0;
  int          bidx_q = 0, bidx_now;

  always #5 clk = ~clk;

  // Registered datapath: A=3*x1+5*x2, B=v*t+c, 4 cycles for the default instance.
  assign bidx_now = sel_d1 ? bidx_q + 1 : 0;
  assign ra_now   = 16'(3 * int'(x1) + 5 * int'(x2));
  assign rb_now   = 16'(int'(v) * int'(t) + int'(c)) ^
                    {15'b0, fault_en && sel && (bidx_now == 7)};

  always @(posedge clk) begin
    sel_d1 <= sel;
    bidx_q <= bidx_now;
    pa[0]  <= ra_now;
    pb[0]  <= rb_now;
    for (int k = 1; k < 4; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
    pa2 <= 16'(3 * int'(x1_2) + 5 * int'(x2_2));
    pb2 <= 16'(int'(v_2) * int'(t_2) + int'(c_2));
  end

  bist_sig_engine #(.GOLDEN_A(GA), .GOLDEN_B(GB)) dut (
    .clk(clk), .rst_n(rst_n), .start_bist(start), .result_a(pa[3]), .result_b(pb[3]),
    .x1_test(x1), .x2_test(x2), .v_test(v), .t_test(t), .c_test(c),
    .sel_eq_test(sel), .bist_active(act), .bist_done(done), .bist_pass(pass),
    .fail_a(fa), .fail_b(fb), .sig_a(sa), .sig_b(sb)
  );

  bist_sig_engine #(.NUM_VEC(1), .LATENCY(1), .GOLDEN_A(GA1), .GOLDEN_B(GB1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_bist(start2), .result_a(pa2), .result_b(pb2),
    .x1_test(x1_2), .x2_test(x2_2), .v_test(v_2), .t_test(t_2), .c_test(c_2),
    .sel_eq_test(sel2), .bist_active(act2), .bist_done(done2), .bist_pass(pass2),
    .fail_a(fa2), .fail_b(fb2), .sig_a(sa2), .sig_b(sb2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_main(input bit fault, input bit stray);
    int   n_act = 0, n0 = 0, n1 = 0, guard = 0;
    exp_t e;
    e.sa   = GA;
    e.sb   = fault ? calc_sig(1'b1, 16, 7) : GB;
    e.fa   = 1'b0;
    e.fb   = fault;
    e.pass = !fault;
    sb_q.push_back(e);
    fault_en = fault;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("act_first",  64'(act),  64'(1));
    chk("x1_first",   64'(x1),   64'(8'hCE));
    chk("done_clr",   64'(done), 64'(0));
    chk("fail_b_clr", 64'(fb),   64'(0));
    while (act && guard < 200) begin
      n_act++;
      if (sel) n1++;
      else     n0++;
      start = stray && sel && (n1 == 3 || n1 == 10);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk("act_len",  64'(n_act), 64'(42));
    chk("sel0_len", 64'(n0),    64'(21));
    chk("sel1_len", 64'(n1),    64'(21));
    chk("done",     64'(done),  64'(1));
    if (sb_q.size() == 0) chk("sb_empty", 64'(1), 64'(0));
    else begin
      e = sb_q.pop_front();
      chk("sig_a",  64'(sa),   64'(e.sa));
      chk("sig_b",  64'(sb),   64'(e.sb));
      chk("fail_a", 64'(fa),   64'(e.fa));
      chk("fail_b", 64'(fb),   64'(e.fb));
      chk("pass",   64'(pass), 64'(e.pass));
    end
  endtask

  initial begin
    int n = 0, guard = 0;
    repeat (3) @(negedge clk);
    chk("rst_flags",  64'({act, done, pass, fa, fb, sel}), 64'(0));
    chk("rst_ops",    64'({x1, x2, v, t, c}), 64'(0));
    chk("rst_sigs",   64'({sa, sb}), 64'(0));
    chk("rst_flags1", 64'({act2, done2, pass2, fa2, fb2, sel2, sa2, sb2}), 64'(0));
    rst_n = 1'b1;

    run_main(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_hold", 64'({done, pass}), 64'(2'b11));
    run_main(1'b1, 1'b0);
    run_main(1'b0, 1'b1);

    // Abort in cycle 10 of RUN_A; reset must land between clock edges.
    fault_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_flags", 64'({act, done, pass, fa, fb, sel}), 64'(0));
    chk("arst_ops",   64'({x1, x2, v, t, c}), 64'(0));
    chk("arst_sigs",  64'({sa, sb}), 64'(0));
    sb_q.delete();
    @(negedge clk); rst_n = 1'b1;
    run_main(1'b0, 1'b0);

    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (act2 && guard < 50) begin
      n++;
      @(negedge clk);
      guard++;
    end
    chk("act_len_n1", 64'(n),     64'(6));
    chk("done_n1",    64'(done2), 64'(1));
    chk("sig_a_n1",   64'(sa2),   64'(16'(3 * 8'hCE + 5 * 8'h0A)));
    chk("sig_b_n1",   64'(sb2),   64'(0));
    chk("pass_n1",    64'({pass2, fa2, fb2}), 64'(3'b100));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
